// File: rtl/macarb8_ctrl_if.sv
// Request/ready/grant bus of the 8-way round-robin arbiter macarb8_ctrl.
// The arbiter side uses the slave modport; the requester/device side uses master.
interface macarb8_ctrl_if;
    logic [7:0] REQ;
    logic [7:0] RDY;
    logic [7:0] GNT;
    logic [2:0] OWNER;
    logic       BUSY;
    logic       ALLRDY;
    logic       TIMEOUT;

    modport master (output REQ, output RDY,
                    input GNT, input OWNER, input BUSY, input ALLRDY, input TIMEOUT);
    modport slave  (input REQ, input RDY,
                    output GNT, output OWNER, output BUSY, output ALLRDY, output TIMEOUT);
endinterface

// File: rtl/macarb8_ctrl.sv
// 8-requester round-robin bus arbiter: IDLE -> GRANT -> DRAIN, one owner at a time.
// Optional grant watchdog enabled by defining MACARB8_TIMEOUT_EN.
module macarb8_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           MasterClock,
    input  logic           RESETL,
    macarb8_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [2:0] owner_r;
    logic [7:0] gnt_r;
    logic       busy_r;
    logic       timeout_r;
    logic [2:0] winner_s;

    // First set request at or above ptr, wrapping 7 -> 0.
    function automatic logic [2:0] pick_winner(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        pick_winner = 3'd0;
        found       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

`ifdef MACARB8_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_r;
`else
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = 8'(TIMEOUT_CYCLES);
`endif

    // Winner selection is a pure function of the live request vector and pointer.
    always_comb begin
        winner_s = pick_winner(bus.REQ, ptr_r);
    end

    assign bus.ALLRDY  = &bus.RDY;
    assign bus.GNT     = gnt_r;
    assign bus.OWNER   = owner_r;
    assign bus.BUSY    = busy_r;
    assign bus.TIMEOUT = timeout_r;

    // Arbitration state machine with registered outputs.
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 3'd0;
            owner_r   <= 3'd0;
            gnt_r     <= 8'h00;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
`ifdef MACARB8_TIMEOUT_EN
            cnt_r     <= 8'd0;
`endif
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|bus.REQ) begin
                        owner_r <= winner_s;
                        gnt_r   <= 8'h01 << winner_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_GRANT;
`ifdef MACARB8_TIMEOUT_EN
                        cnt_r   <= 8'd0;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A voluntary drop takes precedence over the watchdog on the same edge.
                    if (!bus.REQ[owner_r]) begin
                        gnt_r   <= 8'h00;
                        ptr_r   <= owner_r + 3'd1;
                        state_r <= ST_DRAIN;
                    end
`ifdef MACARB8_TIMEOUT_EN
                    else if (cnt_r == TO_LIMIT) begin
                        gnt_r     <= 8'h00;
                        ptr_r     <= owner_r + 3'd1;
                        state_r   <= ST_DRAIN;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
`else
                    else begin
                        gnt_r <= gnt_r;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (bus.ALLRDY) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 8'h00;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macarb8_ctrl.sv
// Self-checking bench for macarb8_ctrl: per-cycle model comparison plus directed literal checks.
// Timeout scenarios run only when MACARB8_TIMEOUT_EN is defined.
module tb_macarb8_ctrl;

    localparam int TCYC = 4;
`ifdef MACARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    macarb8_ctrl_if bus();

    macarb8_ctrl #(.TIMEOUT_CYCLES(TCYC)) dut (
        .MasterClock (clk),
        .RESETL      (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Abstract model: is someone granted, are we waiting for devices, who owns, how long.
    bit m_granted   = 1'b0;
    bit m_draining  = 1'b0;
    int m_owner     = 0;
    int m_next      = 0;
    int m_held      = 0;
    bit m_to        = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_granted <= 1'b0; m_draining <= 1'b0; m_owner <= 0;
            m_next <= 0; m_held <= 0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_granted) begin
                if (!bus.REQ[m_owner]) begin
                    m_granted <= 1'b0; m_draining <= 1'b1; m_next <= (m_owner + 1) % 8;
                end else if (TO_EN && m_held == TCYC) begin
                    m_granted <= 1'b0; m_draining <= 1'b1; m_next <= (m_owner + 1) % 8;
                    m_to <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else if (m_draining) begin
                if (bus.RDY == 8'hFF) m_draining <= 1'b0;
            end else if (bus.REQ != 8'h00) begin
                w = -1;
                for (int k = 0; k < 8; k++)
                    if (w < 0 && bus.REQ[(m_next + k) % 8]) w = (m_next + k) % 8;
                m_owner <= w; m_granted <= 1'b1; m_held <= 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    bit         log_en = 1'b0;
    logic [7:0] prev_gnt = 8'h00;
    int         grant_log[$];

    // Per-cycle comparison against the model, plus grant-order logging.
    always @(negedge clk) begin
        check("gnt", 32'(bus.GNT), m_granted ? 32'(8'h01 << m_owner) : 32'd0);
        check("owner", 32'(bus.OWNER), 32'(m_owner));
        check("busy", 32'(bus.BUSY), 32'(m_granted | m_draining));
        check("timeout", 32'(bus.TIMEOUT), 32'(m_to));
        check("allrdy", 32'(bus.ALLRDY), 32'(bus.RDY == 8'hFF));
        if (log_en && prev_gnt == 8'h00 && bus.GNT != 8'h00) grant_log.push_back(int'(bus.OWNER));
        prev_gnt = bus.GNT;
    end

    task automatic drive(input logic [7:0] rq, input logic [7:0] rd);
        bus.REQ = rq;
        bus.RDY = rd;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        bus.REQ = 8'h00;
        bus.RDY = 8'hFF;
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt", 32'(bus.GNT), 32'h00);
        check("rst_owner", 32'(bus.OWNER), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        check("rst_timeout", 32'(bus.TIMEOUT), 32'h0);
        bus.RDY = 8'h7F;
        #1 check("rst_allrdy_lo", 32'(bus.ALLRDY), 32'h0);
        bus.RDY = 8'hFF;
        #1 check("rst_allrdy_hi", 32'(bus.ALLRDY), 32'h1);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Basic grant, release, drain, regrant.
        drive(8'h05, 8'hFF); tick(1);
        check("t1_gnt0", 32'(bus.GNT), 32'h01);
        check("t1_own0", 32'(bus.OWNER), 32'h0);
        drive(8'h04, 8'hFF); tick(1);
        check("t1_rel_gnt", 32'(bus.GNT), 32'h00);
        check("t1_rel_busy", 32'(bus.BUSY), 32'h1);
        tick(1);
        check("t1_idle_busy", 32'(bus.BUSY), 32'h0);
        tick(1);
        check("t1_gnt2", 32'(bus.GNT), 32'h04);
        check("t1_own2", 32'(bus.OWNER), 32'h2);
        drive(8'h00, 8'hFF); tick(3);

        // Asynchronous reset while owner 4 holds the bus.
        drive(8'h10, 8'hFF); tick(1);
        check("t2_gnt4", 32'(bus.GNT), 32'h10);
        tick(2);
        #1 rst_n = 1'b0;
        #1;
        check("t2_async_gnt", 32'(bus.GNT), 32'h00);
        check("t2_async_busy", 32'(bus.BUSY), 32'h0);
        check("t2_async_owner", 32'(bus.OWNER), 32'h0);
        drive(8'h00, 8'hFF);
        tick(1);
        rst_n = 1'b1;

        // Fair rotation with everyone requesting.
        log_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 8'hFF); tick(3);
            drive(8'hFF & ~(8'h01 << (k % 8)), 8'hFF); tick(2);
        end
        log_en = 1'b0;
        check("t3_log_len", 32'(grant_log.size()), 32'd9);
        for (int k = 0; k < 9 && k < grant_log.size(); k++)
            check("t3_order", 32'(grant_log[k]), 32'(k % 8));

        // Drain waits for every device to be ready.
        drive(8'h02, 8'hFE); tick(1);
        check("t4_gnt1", 32'(bus.GNT), 32'h02);
        drive(8'h00, 8'hFE); tick(1);
        drive(8'h01, 8'hFE);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t4_drain_gnt", 32'(bus.GNT), 32'h00);
            check("t4_drain_busy", 32'(bus.BUSY), 32'h1);
        end
        drive(8'h01, 8'hFF); tick(1);
        check("t4_idle_gnt", 32'(bus.GNT), 32'h00);
        check("t4_idle_busy", 32'(bus.BUSY), 32'h0);
        tick(1);
        check("t4_gnt0", 32'(bus.GNT), 32'h01);
        drive(8'h00, 8'hFF); tick(3);

        // A requester that withdraws before IDLE is never granted.
        drive(8'h08, 8'hFF); tick(1);
        check("t5_gnt3", 32'(bus.GNT), 32'h08);
        drive(8'h28, 8'hFF); tick(1);
        drive(8'h20, 8'hFF); tick(1);
        drive(8'h00, 8'hFF); tick(3);
        check("t5_no_gnt", 32'(bus.GNT), 32'h00);

`ifdef MACARB8_TIMEOUT_EN
        drive(8'h03, 8'hFF); tick(1);
        check("t6_gnt0", 32'(bus.GNT), 32'h01);
        tick(3);
        check("t6_hold", 32'(bus.GNT), 32'h01);
        tick(1);
        check("t6_to_gnt", 32'(bus.GNT), 32'h00);
        check("t6_to_pulse", 32'(bus.TIMEOUT), 32'h1);
        tick(1);
        check("t6_to_end", 32'(bus.TIMEOUT), 32'h0);
        tick(1);
        check("t6_gnt1", 32'(bus.GNT), 32'h02);
        tick(3);
        drive(8'h01, 8'hFF); tick(1);
        check("t7_norm_gnt", 32'(bus.GNT), 32'h00);
        check("t7_no_to", 32'(bus.TIMEOUT), 32'h0);
        tick(2);
        check("t7_gnt0", 32'(bus.GNT), 32'h01);
`else
        drive(8'h03, 8'hFF); tick(1);
        check("t6_gnt0", 32'(bus.GNT), 32'h01);
        tick(10);
        check("t6_hold", 32'(bus.GNT), 32'h01);
        check("t6_no_to", 32'(bus.TIMEOUT), 32'h0);
`endif
        drive(8'h00, 8'hFF); tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/macarb8_ctrl.md
MACARB8_CTRL -- requirements
Module: macarb8_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum GRANT-state dwell in cycles (8-bit range 1..255).
REQ-002 SHALL have port MasterClock, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESETL, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port REQ, input, 8: per-requester bus request, active-high, level.
REQ-005 SHALL have port RDY, input, 8: per-device ready/acknowledge lines, active-high.
REQ-006 SHALL have port GNT, output, 8: registered one-hot grant; all-zero when no owner.
REQ-007 SHALL have port OWNER, output, 3: registered index of the current or last owner.
REQ-008 SHALL have port BUSY, output, 1: registered; high whenever state is not IDLE.
REQ-009 SHALL have port ALLRDY, output, 1: combinational 8-input AND of RDY[7:0].
REQ-010 SHALL have port TIMEOUT, output, 1: registered one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement three states: IDLE, GRANT and DRAIN.
REQ-012 IDLE: on an edge with REQ != 0, SHALL select a winner, set GNT[winner] and OWNER=winner, and enter GRANT (REQ-to-GNT latency one edge).
REQ-013 Winner SHALL be the first set REQ bit searching upward from pointer PTR, wrapping 7->0.
REQ-014 GRANT: SHALL hold GNT while REQ[OWNER]=1; REQ changes on non-owner bits SHALL have no effect.
REQ-015 GRANT: on an edge with REQ[OWNER]=0, SHALL clear GNT, set PTR=(OWNER+1) mod 8 and enter DRAIN.
REQ-016 DRAIN: SHALL remain while ALLRDY=0 and enter IDLE on the first edge with ALLRDY=1; minimum DRAIN dwell is one cycle.
REQ-017 DRAIN: SHALL ignore REQ entirely; the minimum gap from one GNT falling to the next GNT rising is two cycles.
REQ-018 SHALL never assert more than one GNT bit, and SHALL never assert GNT outside GRANT.
REQ-019 OWNER SHALL retain its value through DRAIN and IDLE until the next grant.
REQ-020 A requester that drops REQ in IDLE before being granted SHALL NOT be granted.

Reset
REQ-021 RESETL low SHALL, asynchronously: state=IDLE, GNT=0, OWNER=0, PTR=0, BUSY=0, TIMEOUT=0, timeout counter=0.
REQ-022 Reset mid-GRANT SHALL drop GNT immediately without passing through DRAIN.
REQ-023 First arbitration after reset SHALL start the search at index 0.
REQ-024 ALLRDY SHALL follow RDY regardless of reset.

Configuration
REQ-025 Macro MACARB8_TIMEOUT_EN defined: an 8-bit counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-026 With MACARB8_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES while REQ[OWNER]=1, the block SHALL clear GNT, advance PTR as in REQ-015, enter DRAIN and pulse TIMEOUT for one cycle.
REQ-027 With MACARB8_TIMEOUT_EN, if REQ[OWNER] drops on the same edge the limit is reached, the release SHALL be normal with no TIMEOUT pulse.
REQ-028 With MACARB8_TIMEOUT_EN, a timed-out owner still requesting SHALL compete normally at the next IDLE.
REQ-029 Macro MACARB8_TIMEOUT_EN undefined: no counter, TIMEOUT tied 0, TIMEOUT_CYCLES ignored, and GRANT lasts indefinitely.

Verification
REQ-030 Reset, RDY=FF, REQ=0x05 -> GNT=0x01 one edge later, OWNER=0; drop REQ[0] -> GNT=0, DRAIN then IDLE, then GNT=0x04.
REQ-031 REQ=FF held constant, each owner releasing after 3 cycles -> grant order 0,1,...,7,0; never two GNT bits set.
REQ-032 Owner releases with RDY=0xFE, RDY[0] raised 5 cycles later -> BUSY stays high, no grant until the edge after ALLRDY=1.
REQ-033 RESETL low mid-GRANT with GNT=0x10 -> GNT=0 and BUSY=0 immediately without a clock; next grant searches from 0.
REQ-034 MACARB8_TIMEOUT_EN, TIMEOUT_CYCLES=4, REQ=0x03 held -> GNT=0x01 for 4 cycles, TIMEOUT one-cycle pulse, then GNT=0x02.
REQ-035 MACARB8_TIMEOUT_EN, owner drops REQ on the limit edge -> TIMEOUT stays 0 and the release is normal.
